branch_resolve_unit: RTL and testbench

- Parametrised, registered successor to the single-cycle Branch comparator, for the pipelined core's EX stage.
- Decodes the RV32I branch funct3 and performs signed/unsigned compare at width XLEN.
- Computes the branch target and fall-through address, and flags mispredictions against the front-end's predicted-taken bit.
- Uses a valid/ready handshake and a flush input, and keeps saturating branch/mispredict statistics counters.

---
 rtl/branch_resolve_unit.sv | 159 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered RV32I branch resolve stage with handshake, flush and statistics
module branch_resolve_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned INSN_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  dataR1,
    input  logic [XLEN-1:0]  dataR2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             br_eq,
    output logic             br_lt,
    output logic             taken,
    output logic             illegal,
    output logic             mispredict,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispredict
);

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic             w_eq;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_lt;
    logic             w_taken;
    logic             w_illegal;
    logic             w_mispredict;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_fall;
    logic [XLEN-1:0]  w_redirect;
    logic             w_accept;
    logic             w_complete;

    logic             r_valid;
    logic             r_eq;
    logic             r_lt;
    logic             r_taken;
    logic             r_illegal;
    logic             r_mispredict;
    logic [XLEN-1:0]  r_target;
    logic [XLEN-1:0]  r_redirect;
    logic [CNT_W-1:0] r_cnt_branch;
    logic [CNT_W-1:0] r_cnt_mispredict;

    // Compare operands; signed order only for BLT/BGE, unsigned otherwise
    always_comb begin
        w_eq   = (dataR1 == dataR2);
        w_lt_s = ($signed(dataR1) < $signed(dataR2));
        w_lt_u = (dataR1 < dataR2);
        w_lt   = (funct3[2:1] == 2'b10) ? w_lt_s : w_lt_u;
    end

    // Decode branch type into a direction; reserved encodings resolve not-taken
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (funct3)
            F3_BEQ:          w_taken = w_eq;
            F3_BNE:          w_taken = ~w_eq;
            F3_BLT, F3_BLTU: w_taken = w_lt;
            F3_BGE, F3_BGEU: w_taken = ~w_lt;
            default:         w_illegal = 1'b1;
        endcase
    end

    // Address arithmetic wraps at XLEN bits; carries are simply dropped
    always_comb begin
        w_target     = pc + imm;
        w_fall       = pc + XLEN'(INSN_BYTES);
        w_redirect   = w_taken ? w_target : w_fall;
        w_mispredict = w_taken ^ pred_taken;
    end

    assign in_ready   = ~r_valid | out_ready;
    assign w_accept   = in_valid & in_ready & ~flush;
    assign w_complete = r_valid & out_ready & ~flush;

    // Output valid: flush kills, accept fills, downstream acceptance drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Result payload only changes on accept, so it stays stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq         <= 1'b0;
            r_lt         <= 1'b0;
            r_taken      <= 1'b0;
            r_illegal    <= 1'b0;
            r_mispredict <= 1'b0;
            r_target     <= '0;
            r_redirect   <= '0;
        end else if (w_accept) begin
            r_eq         <= w_eq;
            r_lt         <= w_lt;
            r_taken      <= w_taken;
            r_illegal    <= w_illegal;
            r_mispredict <= w_mispredict;
            r_target     <= w_target;
            r_redirect   <= w_redirect;
        end
    end

    // Saturating statistics; clear wins over a same-edge completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_branch     <= '0;
            r_cnt_mispredict <= '0;
        end else if (clr_cnt) begin
            r_cnt_branch     <= '0;
            r_cnt_mispredict <= '0;
        end else if (w_complete) begin
            if (r_cnt_branch != {CNT_W{1'b1}}) begin
                r_cnt_branch <= r_cnt_branch + CNT_W'(1);
            end
            if (r_mispredict && (r_cnt_mispredict != {CNT_W{1'b1}})) begin
                r_cnt_mispredict <= r_cnt_mispredict + CNT_W'(1);
            end
        end
    end

    assign out_valid      = r_valid;
    assign br_eq          = r_eq;
    assign br_lt          = r_lt;
    assign taken          = r_taken;
    assign illegal        = r_illegal;
    assign mispredict     = r_mispredict;
    assign target         = r_target;
    assign redirect_pc    = r_redirect;
    assign cnt_branch     = r_cnt_branch;
    assign cnt_mispredict = r_cnt_mispredict;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and random checks of branch_resolve_unit against a reference model
module tb_branch_resolve_unit;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    funct3 = 3'b000;
    logic [31:0]   dataR1 = '0;
    logic [31:0]   dataR2 = '0;
    logic [31:0]   pc = '0;
    logic [31:0]   imm = '0;
    logic          pred_taken = 1'b0;
    logic          flush = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          br_eq;
    logic          br_lt;
    logic          taken;
    logic          illegal;
    logic          mispredict;
    logic [31:0]   target;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] cnt_branch;
    logic [CW-1:0] cnt_mispredict;

    branch_resolve_unit #(.XLEN(32), .CNT_W(CW), .INSN_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .dataR1(dataR1), .dataR2(dataR2), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .flush(flush), .clr_cnt(clr_cnt),
        .out_valid(out_valid), .out_ready(out_ready), .br_eq(br_eq), .br_lt(br_lt),
        .taken(taken), .illegal(illegal), .mispredict(mispredict), .target(target),
        .redirect_pc(redirect_pc), .cnt_branch(cnt_branch), .cnt_mispredict(cnt_mispredict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        eq;
        logic        lt;
        logic        tk;
        logic        ill;
        logic        mis;
        logic [31:0] tgt;
        logic [31:0] rpc;
    } res_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_valid  = 1'b0;
    res_t m_res;
    int   m_cb = 0;
    int   m_cm = 0;
    logic [31:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t ref_resolve(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] p, input logic [31:0] i, input logic pt);
        res_t r;
        int   sa;
        int   sb;
        sa = a;
        sb = b;
        r.eq  = (a == b);
        r.lt  = (f == 3'd4 || f == 3'd5) ? (sa < sb) : (a < b);
        r.ill = (f == 3'd2 || f == 3'd3);
        case (f)
            3'd0:       r.tk = r.eq;
            3'd1:       r.tk = !r.eq;
            3'd4, 3'd6: r.tk = r.lt;
            3'd5, 3'd7: r.tk = !r.lt;
            default:    r.tk = 1'b0;
        endcase
        r.mis = (r.tk != pt);
        r.tgt = p + i;
        r.rpc = r.tk ? r.tgt : p + 32'd4;
        return r;
    endfunction

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("br_eq", {31'd0, br_eq}, {31'd0, m_res.eq});
            chk("br_lt", {31'd0, br_lt}, {31'd0, m_res.lt});
            chk("taken", {31'd0, taken}, {31'd0, m_res.tk});
            chk("illegal", {31'd0, illegal}, {31'd0, m_res.ill});
            chk("mispredict", {31'd0, mispredict}, {31'd0, m_res.mis});
            chk("target", target, m_res.tgt);
            chk("redirect_pc", redirect_pc, m_res.rpc);
        end
        chk("cnt_branch", {30'd0, cnt_branch}, m_cb);
        chk("cnt_mispredict", {30'd0, cnt_mispredict}, m_cm);
    endtask

    // One clock: check handshake before the edge, advance the model, check results after
    task automatic tick();
        logic rdy;
        logic acc;
        logic cmp;
        #1;
        rdy = !m_valid || out_ready;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        acc = in_valid && rdy && !flush;
        cmp = m_valid && out_ready && !flush;
        @(posedge clk);
        if (clr_cnt) begin
            m_cb = 0;
            m_cm = 0;
        end else if (cmp) begin
            if (m_cb < CMAX) m_cb++;
            if (m_res.mis && m_cm < CMAX) m_cm++;
        end
        if (flush) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_res = ref_resolve(funct3, dataR1, dataR2, pc, imm, pred_taken);
        end else if (out_ready) m_valid = 1'b0;
        #1;
        check_outputs();
    endtask

    task automatic req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i, input logic pt);
        in_valid = 1'b1;
        funct3 = f; dataR1 = a; dataR2 = b; pc = p; imm = i; pred_taken = pt;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_taken", {31'd0, taken}, 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_cnt_branch", {30'd0, cnt_branch}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // BLT signed, BLTU unsigned, BEQ
        out_ready = 1'b1;
        req(3'b100, 32'd15, 32'hFFFF_FFEC, 32'h100, 32'h20, 1'b1);
        tick();
        chk("blt_br_lt", {31'd0, br_lt}, 32'd0);
        chk("blt_mispredict", {31'd0, mispredict}, 32'd1);
        chk("blt_redirect", redirect_pc, 32'h104);
        chk("blt_target", target, 32'h120);
        req(3'b110, 32'd15, 32'hFFFF_FFEC, 32'h100, 32'h20, 1'b0);
        tick();
        chk("bltu_br_lt", {31'd0, br_lt}, 32'd1);
        chk("bltu_taken", {31'd0, taken}, 32'd1);
        chk("bltu_redirect", redirect_pc, 32'h120);
        req(3'b000, 32'd20, 32'd20, 32'h200, 32'h40, 1'b1);
        tick();
        chk("beq_br_eq", {31'd0, br_eq}, 32'd1);
        chk("beq_taken", {31'd0, taken}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("three_done", {30'd0, cnt_branch}, 32'd3);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;

        // backpressure
        out_ready = 1'b0;
        req(3'b001, 32'd1, 32'd2, 32'h300, 32'h10, 1'b0);
        tick();
        held = target;
        req(3'b101, 32'd7, 32'd3, 32'h400, 32'h80, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold", target, 32'h310);
        end
        out_ready = 1'b1;
        tick();
        req(3'b111, 32'd3, 32'd9, 32'h500, 32'hFFFF_FFF0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("bp_cnt_branch", {30'd0, cnt_branch}, 32'd3);

        // flush with a held result and a new request
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        req(3'b000, 32'd5, 32'd5, 32'h600, 32'h8, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_cnt", {30'd0, cnt_branch}, 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();

        // wrap and illegal encoding
        req(3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 1'b0);
        tick();
        chk("wrap_target", target, 32'h4);
        chk("wrap_redirect", redirect_pc, 32'h0);
        req(3'b011, 32'd1, 32'd1, 32'h700, 32'h4, 1'b1);
        tick();
        chk("ill_illegal", {31'd0, illegal}, 32'd1);
        chk("ill_taken", {31'd0, taken}, 32'd0);
        chk("ill_mispredict", {31'd0, mispredict}, 32'd1);
        in_valid = 1'b0;
        tick();

        // saturation and clear-over-completion
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        req(3'b000, 32'd1, 32'd2, 32'h800, 32'h4, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        in_valid = 1'b0;
        tick();
        chk("sat_branch", {30'd0, cnt_branch}, 32'd3);
        chk("sat_mispredict", {30'd0, cnt_mispredict}, 32'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clr_cnt = 1'b1;
        tick();
        chk("clr_branch", {30'd0, cnt_branch}, 32'd0);
        chk("clr_mispredict", {30'd0, cnt_mispredict}, 32'd0);
        clr_cnt = 1'b0;

        // reset asserted mid-stall
        out_ready = 1'b0;
        req(3'b100, 32'd1, 32'd9, 32'h900, 32'h4, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        m_valid = 1'b0;
        m_cb = 0;
        m_cm = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 9) == 0);
            clr_cnt    = ($urandom_range(0, 19) == 0);
            funct3     = 3'($urandom_range(0, 7));
            dataR1     = $urandom;
            dataR2     = ($urandom_range(0, 3) == 0) ? dataR1 : $urandom;
            if ($urandom_range(0, 3) == 0) dataR1 = {dataR2[31], 31'($urandom_range(0, 15))};
            pc         = $urandom;
            imm        = $urandom;
            pred_taken = 1'($urandom_range(0, 1));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
